difftest_multi_endpoint_ctrl: RTL

Synthesizable multi-core successor to the single-core simulation endpoint. It monitors N cores' difftest step counts, exit codes and UART output. It keeps per-core stuck timers and a global cycle budget, and merges all cores' UART bytes into one buffered, core-tagged stream. It sits between the DUT's per-core difftest top IO and the host/testbench (or FPGA host link) and reports a single terminal simulation status.

---
 rtl/difftest_multi_endpoint_ctrl_if.sv | 39 +++
 rtl/difftest_multi_endpoint_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/difftest_multi_endpoint_ctrl_if.sv
// Bundle of per-core difftest inputs, merged UART stream and terminal status
// shared between the endpoint controller (slave) and its environment (master).
interface difftest_multi_endpoint_ctrl_if #(
    parameter int NUM_CORES  = 2,
    parameter int STEP_WIDTH = 8
);
    localparam int CW = $clog2((NUM_CORES > 1) ? NUM_CORES : 2);

    logic [NUM_CORES*STEP_WIDTH-1:0] core_step;
    logic [NUM_CORES*64-1:0]         core_exit;
    logic [NUM_CORES-1:0]            core_uart_valid;
    logic [NUM_CORES*8-1:0]          core_uart_ch;
    logic [63:0]                     max_cycles;
    logic [63:0]                     stuck_limit;
    logic                            uart_out_ready;
    logic                            uart_out_valid;
    logic [7:0]                      uart_out_ch;
    logic [CW-1:0]                   uart_out_core;
    logic [1:0]                      sim_state;
    logic [63:0]                     fail_code;
    logic [CW-1:0]                   fail_core;
    logic                            perf_dump;
    logic [63:0]                     n_cycles;
    logic [15:0]                     uart_drop_cnt;

    modport master (
        output core_step, core_exit, core_uart_valid, core_uart_ch,
               max_cycles, stuck_limit, uart_out_ready,
        input  uart_out_valid, uart_out_ch, uart_out_core, sim_state,
               fail_code, fail_core, perf_dump, n_cycles, uart_drop_cnt
    );

    modport slave (
        input  core_step, core_exit, core_uart_valid, core_uart_ch,
               max_cycles, stuck_limit, uart_out_ready,
        output uart_out_valid, uart_out_ch, uart_out_core, sim_state,
               fail_code, fail_core, perf_dump, n_cycles, uart_drop_cnt
    );
endinterface

// File: rtl/difftest_multi_endpoint_ctrl.sv
// Multi-core simulation endpoint: watches N cores for exit/error/stall, enforces a
// cycle budget, and merges per-core UART bytes into one core-tagged FIFO stream.
module difftest_multi_endpoint_ctrl #(
    parameter int NUM_CORES  = 2,
    parameter int STEP_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input logic                          clock,
    input logic                          reset,
    difftest_multi_endpoint_ctrl_if.slave io
);
    localparam int CW = $clog2((NUM_CORES > 1) ? NUM_CORES : 2);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = CW + 8;
    localparam logic [63:0] EXIT_OK = '1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DONE    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } sim_state_e;

    sim_state_e           state_q, state_d;
    logic [63:0]          fail_code_q, fail_code_d;
    logic [CW-1:0]        fail_core_q, fail_core_d;
    logic                 perf_dump_q, perf_dump_d;
    logic [63:0]          n_cycles_q, n_cycles_d;
    logic [NUM_CORES-1:0] exited_q, exited_d;
    logic [63:0]          timer_q [NUM_CORES];
    logic [63:0]          timer_d [NUM_CORES];

    logic [NUM_CORES-1:0] hold_valid_q, hold_valid_d;
    logic [7:0]           hold_ch_q [NUM_CORES];
    logic [7:0]           hold_ch_d [NUM_CORES];
    logic [15:0]          drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]        last_grant_q, last_grant_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]        mem [FIFO_DEPTH];

    logic                 fail_hit, stuck_hit;
    logic [CW-1:0]        fail_idx, stuck_idx;
    logic [63:0]          fail_val, exit_i;
    logic [STEP_WIDTH-1:0] step_i;

    // NOTE: every variable gets a default at the top of an always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        fail_core_d = fail_core_q;
        perf_dump_d = 1'b0;
        n_cycles_d  = n_cycles_q;
        exited_d    = exited_q;
        fail_hit    = 1'b0;
        fail_idx    = '0;
        fail_val    = '0;
        stuck_hit   = 1'b0;
        stuck_idx   = '0;
        exit_i      = '0;
        step_i      = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            exit_i = io.core_exit[i*64 +: 64];
            step_i = io.core_step[i*STEP_WIDTH +: STEP_WIDTH];
            if (exit_i == EXIT_OK) exited_d[i] = 1'b1;
            // Error and stall checks use the flag from before this cycle's exit.
            if (!exited_q[i] && !fail_hit && exit_i != '0 && exit_i != EXIT_OK) begin
                fail_hit = 1'b1;
                fail_idx = CW'(i);
                fail_val = exit_i;
            end
            if (!exited_q[i] && !stuck_hit && io.stuck_limit != '0 &&
                timer_q[i] >= io.stuck_limit) begin
                stuck_hit = 1'b1;
                stuck_idx = CW'(i);
            end
            if (step_i != '0)            timer_d[i] = '0;
            else if (timer_q[i] == '1)   timer_d[i] = timer_q[i];
            else                         timer_d[i] = timer_q[i] + 64'd1;
        end

        if (state_q == ST_RUN) begin
            n_cycles_d = n_cycles_q + 64'd1;
            if (fail_hit) begin
                state_d     = ST_FAIL;
                fail_code_d = fail_val;
                fail_core_d = fail_idx;
                perf_dump_d = 1'b1;
            end else if (stuck_hit) begin
                state_d     = ST_TIMEOUT;
                fail_core_d = stuck_idx;
                perf_dump_d = 1'b1;
            end else if (io.max_cycles != '0 && n_cycles_q >= io.max_cycles) begin
                state_d     = ST_TIMEOUT;
                perf_dump_d = 1'b1;
            end else if (&exited_d) begin
                state_d     = ST_DONE;
                perf_dump_d = 1'b1;
            end
        end
    end

    logic [AW:0]   fifo_count;
    logic          fifo_full, fifo_pop, fifo_push, can_push;
    logic          grant_hit;
    logic [CW-1:0] grant_idx, cand;
    logic [4:0]    n_drop;
    logic [16:0]   drop_sum;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign fifo_pop   = (fifo_count != '0) && io.uart_out_ready;
    assign can_push   = !fifo_full || fifo_pop;

    always_comb begin
        grant_hit    = 1'b0;
        grant_idx    = '0;
        cand         = '0;
        n_drop       = '0;
        hold_valid_d = hold_valid_q;
        hold_ch_d    = hold_ch_q;
        // Round-robin: first occupied holding register after the last grant.
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = CW'((int'(last_grant_q) + 1 + k) % NUM_CORES);
            if (!grant_hit && hold_valid_q[cand]) begin
                grant_hit = 1'b1;
                grant_idx = cand;
            end
        end
        fifo_push = grant_hit && can_push;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (fifo_push && grant_idx == CW'(i)) hold_valid_d[i] = 1'b0;
            if (io.core_uart_valid[i]) begin
                if (!hold_valid_d[i]) begin
                    hold_valid_d[i] = 1'b1;
                    hold_ch_d[i]    = io.core_uart_ch[i*8 +: 8];
                end else begin
                    n_drop = n_drop + 5'd1;
                end
            end
        end
        drop_sum     = {1'b0, drop_cnt_q} + {12'd0, n_drop};
        drop_cnt_d   = drop_sum[16] ? 16'hffff : drop_sum[15:0];
        last_grant_d = fifo_push ? grant_idx : last_grant_q;
        wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, fifo_push};
        rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, fifo_pop};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            fail_code_q  <= '0;
            fail_core_q  <= '0;
            perf_dump_q  <= 1'b0;
            n_cycles_q   <= '0;
            exited_q     <= '0;
            hold_valid_q <= '0;
            drop_cnt_q   <= '0;
            last_grant_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                timer_q[i]   <= '0;
                hold_ch_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            fail_code_q  <= fail_code_d;
            fail_core_q  <= fail_core_d;
            perf_dump_q  <= perf_dump_d;
            n_cycles_q   <= n_cycles_d;
            exited_q     <= exited_d;
            hold_valid_q <= hold_valid_d;
            drop_cnt_q   <= drop_cnt_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            timer_q      <= timer_d;
            hold_ch_q    <= hold_ch_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers define validity, so stale
    // entries are unreachable after reset and the array maps to plain RAM.
    always_ff @(posedge clock) begin
        if (!reset && fifo_push) mem[wr_ptr_q[AW-1:0]] <= {grant_idx, hold_ch_q[grant_idx]};
    end

    logic [EW-1:0] head;
    assign head = mem[rd_ptr_q[AW-1:0]];

    assign io.uart_out_valid = fifo_count != '0;
    assign io.uart_out_ch    = head[7:0];
    assign io.uart_out_core  = head[EW-1:8];
    assign io.sim_state      = state_q;
    assign io.fail_code      = fail_code_q;
    assign io.fail_core      = fail_core_q;
    assign io.perf_dump      = perf_dump_q;
    assign io.n_cycles       = n_cycles_q;
    assign io.uart_drop_cnt  = drop_cnt_q;
endmodule
